// File: rtl/psum_post.sv
// psum_post: post-processing stage behind the signed MAC.
// Adds a per-channel bias and round-shifts the sum. The result is saturated
// to WIDTH, then passed through an optional ReLU. Results are buffered in a
// small valid/ready FIFO. A credit-style psum_ready goes back to the MAC
// sequencer, and sticky saturation/drop flags record exceptions.
module psum_post #(
  parameter int WIDTH   = 16,
  parameter int SHIFT   = 4,
  parameter int DEPTH   = 4,
  parameter int RELU_EN = 1
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic signed [WIDTH-1:0] psum_in,
  input  logic                    psum_last,
  input  logic signed [WIDTH-1:0] bias,
  output logic                    psum_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_flag,
  output logic                    drop_flag
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int SUM_W   = WIDTH + 2;
  localparam int RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;

  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(RND_INT);
  localparam logic signed [SUM_W-1:0] MAX_V = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]        PTR_ONE   = PTR_W'(1);

  // Stage 1 registers
  logic signed [SUM_W-1:0] s1_sum;
  logic                    s1_valid;

  // Stage 2 combinational results
  logic signed [SUM_W-1:0] s2_rnd;
  logic signed [SUM_W-1:0] s2_shr;
  logic signed [WIDTH-1:0] s2_sat;
  logic signed [WIDTH-1:0] s2_data;
  logic                    s2_clamp;

  // FIFO state
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        rd_ptr_inc;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;

  logic accept;
  logic push;
  logic pop;

  // Credit accounting counts the in-flight stage-1 result as occupied, so a
  // stage-2 write can never meet a full FIFO. A same-cycle pop is not credited.
  always_comb begin
    psum_ready = (count + CNT_W'(s1_valid)) < CNT_DEPTH;
    accept     = psum_last & psum_ready;
    push       = s1_valid;
    pop        = out_valid & out_ready;
    rd_ptr_inc = rd_ptr + PTR_ONE;
  end

  // Stage 1: capture the completed dot product plus bias in a widened sum
  always_ff @(posedge clk) begin
    if (rstb) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum <= {{2{psum_in[WIDTH-1]}}, psum_in} + {{2{bias[WIDTH-1]}}, bias};
      end
    end
  end

  // Stage 2: round half up, arithmetic shift, saturate, then optional ReLU
  always_comb begin
    s2_rnd   = s1_sum + RND;
    s2_shr   = s2_rnd >>> SHIFT;
    s2_sat   = s2_shr[WIDTH-1:0];
    s2_clamp = 1'b0;
    if (s2_shr > MAX_V) begin
      s2_sat   = {1'b0, {(WIDTH-1){1'b1}}};
      s2_clamp = 1'b1;
    end else if (s2_shr < MIN_V) begin
      s2_sat   = {1'b1, {(WIDTH-1){1'b0}}};
      s2_clamp = 1'b1;
    end
    s2_data = s2_sat;
    if ((RELU_EN != 0) && s2_sat[WIDTH-1]) begin
      s2_data = '0;
    end
  end

  // Occupancy after this cycle's push and pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // FIFO storage is written at the tail whenever stage 2 holds a result
  always_ff @(posedge clk) begin
    if (!rstb && push) begin
      mem[wr_ptr] <= s2_data;
    end
  end

  // FIFO pointers, count and the registered head/valid outputs
  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr_inc;
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (pop) begin
        if (count >= CNT_W'(2)) begin
          out_data <= mem[rd_ptr_inc];
        end else if (push) begin
          out_data <= s2_data;
        end
      end else if ((count == '0) && push) begin
        out_data <= s2_data;
      end
    end
  end

  // Sticky exception flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rstb) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (s1_valid && s2_clamp)      sat_flag  <= 1'b1;
      if (psum_last && !psum_ready)  drop_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_post.sv
// tb_psum_post: table-driven checks of psum_post across three parameter sets
// sharing one input stream, plus hand-written multi-cycle sequences.
module tb_psum_post;

  localparam int W = 16;

  logic clk;
  logic rstb;
  logic signed [W-1:0] psum_in;
  logic signed [W-1:0] bias;
  logic psum_last;
  logic out_ready;

  logic signed [W-1:0] out_data_a, out_data_b, out_data_c;
  logic out_valid_a, out_valid_b, out_valid_c;
  logic ready_a, ready_b, ready_c;
  logic sat_a, sat_b, sat_c;
  logic drop_a, drop_b, drop_c;

  int tests;
  int failed;

  typedef struct {
    int psum;
    int bias;
    int exp_a;
    int exp_b;
    int exp_c;
    int exp_sat_c;
  } vec_t;

  vec_t vec [9];

  psum_post #(.WIDTH(W), .SHIFT(4), .DEPTH(4), .RELU_EN(1)) dut_a (
    .clk(clk), .rstb(rstb), .psum_in(psum_in), .psum_last(psum_last), .bias(bias),
    .psum_ready(ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .sat_flag(sat_a), .drop_flag(drop_a));

  psum_post #(.WIDTH(W), .SHIFT(4), .DEPTH(4), .RELU_EN(0)) dut_b (
    .clk(clk), .rstb(rstb), .psum_in(psum_in), .psum_last(psum_last), .bias(bias),
    .psum_ready(ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .sat_flag(sat_b), .drop_flag(drop_b));

  psum_post #(.WIDTH(W), .SHIFT(0), .DEPTH(4), .RELU_EN(0)) dut_c (
    .clk(clk), .rstb(rstb), .psum_in(psum_in), .psum_last(psum_last), .bias(bias),
    .psum_ready(ready_c), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_ready(out_ready), .sat_flag(sat_c), .drop_flag(drop_c));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input int b);
    psum_in   = W'(p);
    bias      = W'(b);
    psum_last = 1'b1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rstb      = 1'b1;
    psum_last = 1'b0;
    step();
    rstb = 1'b0;
  endtask

  initial begin
    int ma [8];
    int mb [8];
    int dot;

    tests     = 0;
    failed    = 0;
    rstb      = 1'b1;
    psum_in   = '0;
    bias      = '0;
    psum_last = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rstb = 1'b0;

    // Reset state
    checkOutput("reset out_valid", int'(out_valid_a), 0);
    checkOutput("reset out_data", int'(out_data_a), 0);
    checkOutput("reset sat_flag", int'(sat_a), 0);
    checkOutput("reset drop_flag", int'(drop_a), 0);
    checkOutput("reset psum_ready", int'(ready_a), 1);

    // MAC dot product feeding the first vector
    ma  = '{1, 4, 7, -2, 3, -5, 2, 3};
    mb  = '{4, -3, 2, -1, 2, 1, -5, 7};
    dot = 0;
    for (int i = 0; i < 8; i++) dot += ma[i] * mb[i];

    vec[0] = '{dot,    12,    2,    2,     32,     0};
    vec[1] = '{100,    0,     6,    6,     100,    0};
    vec[2] = '{-100,   0,     0,    -6,    -100,   0};
    vec[3] = '{24,     0,     2,    2,     24,     0};
    vec[4] = '{8,      0,     1,    1,     8,      0};
    vec[5] = '{-9,     0,     0,    -1,    -9,     0};
    vec[6] = '{32767,  32767, 4096, 4096,  32767,  1};
    vec[7] = '{-32768, -1,    0,    -2048, -32768, 1};
    vec[8] = '{-5,     3,     0,    0,     -2,     1};

    // Single results through all three parameter sets
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vec[i].psum, vec[i].bias);
      step();
      psum_last = 1'b0;
      checkOutput($sformatf("vec%0d latency valid", i), int'(out_valid_a), 0);
      step();
      checkOutput($sformatf("vec%0d valid", i), int'(out_valid_a), 1);
      checkOutput($sformatf("vec%0d relu_out", i), int'(out_data_a), vec[i].exp_a);
      checkOutput($sformatf("vec%0d signed_out", i), int'(out_data_b), vec[i].exp_b);
      checkOutput($sformatf("vec%0d noshift_out", i), int'(out_data_c), vec[i].exp_c);
      checkOutput($sformatf("vec%0d sat_c", i), int'(sat_c), vec[i].exp_sat_c);
      checkOutput($sformatf("vec%0d sat_a", i), int'(sat_a), 0);
      step();
      checkOutput($sformatf("vec%0d popped", i), int'(out_valid_a), 0);
    end
    checkOutput("table drop_flag", int'(drop_a), 0);

    // Backpressure: fill FIFO, overflow is dropped, then drain in order
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp ready before push%0d", i), int'(ready_a), 1);
      applyStimulus(16 * (i + 1), 0);
      step();
    end
    checkOutput("bp ready after 4th", int'(ready_a), 0);
    applyStimulus(160, 0);
    step();
    psum_last = 1'b0;
    checkOutput("bp drop_flag", int'(drop_a), 1);
    step();
    checkOutput("bp ready still low", int'(ready_a), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp drain valid%0d", i), int'(out_valid_a), 1);
      checkOutput($sformatf("bp drain data%0d", i), int'(out_data_a), i + 1);
      step();
    end
    checkOutput("bp empty valid", int'(out_valid_a), 0);
    checkOutput("bp hold last data", int'(out_data_a), 4);
    checkOutput("bp ready restored", int'(ready_a), 1);

    // Reset mid-operation: stage 1 busy and three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16 * (i + 5), 0);
      step();
    end
    psum_last = 1'b0;
    doReset();
    checkOutput("midrst valid", int'(out_valid_a), 0);
    checkOutput("midrst drop", int'(drop_a), 0);
    checkOutput("midrst sat_c", int'(sat_c), 0);
    checkOutput("midrst ready", int'(ready_a), 1);
    checkOutput("midrst data", int'(out_data_a), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("midrst no output%0d", i), int'(out_valid_a), 0);
    end

    // Concurrent push/pop with two entries queued
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(16 * (i + 1), 0);
      step();
    end
    psum_last = 1'b0;
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("cc valid%0d", k), int'(out_valid_a), 1);
      checkOutput($sformatf("cc data%0d", k), int'(out_data_a), k + 1);
      checkOutput($sformatf("cc ready%0d", k), int'(ready_a), 1);
      applyStimulus(16 * (k + 3), 0);
      step();
    end
    psum_last = 1'b0;
    for (int k = 6; k < 8; k++) begin
      checkOutput($sformatf("cc tail valid%0d", k), int'(out_valid_a), 1);
      checkOutput($sformatf("cc tail data%0d", k), int'(out_data_a), k + 1);
      step();
    end
    checkOutput("cc empty", int'(out_valid_a), 0);
    checkOutput("cc no drop", int'(drop_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
